uart_alu_interface: RTL

Byte-level control stage between the UART and the ALU. Collects three received bytes: operand A, operand B and opcode, from the UART receiver. It presents them to the ALU, captures the ALU result, and hands the result byte to the UART transmitter with a one-cycle start pulse. It then waits for transmit completion before accepting the next frame.

---
 rtl/uart_alu_interface.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_alu_interface.sv
// Byte-level control stage: collects A, B and opcode bytes from the UART receiver, presents them to the ALU,
// and hands the result to the UART transmitter. Optional inter-byte timeout is enabled by defining IFACE_TIMEOUT_EN.
module uart_alu_interface #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rx_done_bit,
    input  logic [DATA_WIDTH-1:0] i_rx_data_byte,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_done_bit,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_tx_data_byte,
    output logic                  o_tx_signal,
    output logic                  o_busy,
    output logic                  o_timeout
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        COMPUTE,
        SEND,
        WAIT_TX
    } state_t;

    state_t state_reg, state_next;
    logic   timeout_hit;
    logic   collecting;

    assign collecting = (state_reg == WAIT_B) || (state_reg == WAIT_OP);

`ifdef IFACE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_reg;

    // A byte arriving on the terminal count still wins over the abort.
    assign timeout_hit = collecting && !i_rx_done_bit &&
                         (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_hit;
            if (collecting && !i_rx_done_bit && !timeout_hit)
                cnt_reg <= cnt_reg + 1'b1;
            else
                cnt_reg <= '0;
        end
    end

    assign o_timeout = timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= WAIT_A;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_A:  if (i_rx_done_bit) state_next = WAIT_B;
            WAIT_B: begin
                if (i_rx_done_bit)    state_next = WAIT_OP;
                else if (timeout_hit) state_next = WAIT_A;
            end
            WAIT_OP: begin
                if (i_rx_done_bit)    state_next = COMPUTE;
                else if (timeout_hit) state_next = WAIT_A;
            end
            COMPUTE: state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: if (i_tx_done_bit) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    // Datapath registers load only in their own state, so late bytes never disturb a frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_alu_a        <= '0;
            o_alu_b        <= '0;
            o_alu_op       <= '0;
            o_tx_data_byte <= '0;
            o_tx_signal    <= 1'b0;
        end else begin
            o_tx_signal <= (state_reg == SEND);
            case (state_reg)
                WAIT_A:  if (i_rx_done_bit) o_alu_a  <= i_rx_data_byte;
                WAIT_B:  if (i_rx_done_bit) o_alu_b  <= i_rx_data_byte;
                WAIT_OP: if (i_rx_done_bit) o_alu_op <= i_rx_data_byte[OP_WIDTH-1:0];
                COMPUTE: o_tx_data_byte <= i_alu_result;
                default: ;
            endcase
        end
    end

    assign o_busy = (state_reg == COMPUTE) || (state_reg == SEND) || (state_reg == WAIT_TX);

endmodule
